// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit valid/ready output channel
// between four requesters, granting bursts of up to MAX_BURST beats.
//
// state | meaning
// IDLE  | no grant held; pick the next requester in priority order from ptr
// SERVE | grant held by requester sel; beats forwarded until burst end or release
module rr_mux_arbiter #(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         req,
   input  logic [4*WIDTH-1:0] din,
   output logic [3:0]         ack,
   output logic [1:0]         sel,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   localparam logic [3:0] BURST_LAST = 4'(MAX_BURST);

   state_t           state, state_nxt;
   logic [1:0]       ptr, ptr_nxt;
   logic [1:0]       sel_nxt;
   logic [3:0]       beat_cnt, beat_cnt_nxt;
   logic [1:0]       winner;
   logic [1:0]       cand;
   logic             found;
   logic             xfer;
   logic [WIDTH-1:0] din_arr [4];

   for (genvar g = 0; g < 4; g++) begin : g_din_split
      assign din_arr[g] = din[g*WIDTH +: WIDTH];
   end

   // First set request bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
   always_comb begin
      winner = ptr;
      found  = 1'b0;
      cand   = ptr;
      for (int k = 0; k < 4; k++) begin
         cand = ptr + 2'(k);
         if (!found && req[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      busy      = (state == SERVE);
      out_valid = busy && req[sel];
      out_data  = out_valid ? din_arr[sel] : '0;
      xfer      = out_valid && out_ready;
      ack       = xfer ? (4'b0001 << sel) : 4'b0000;
   end

   always_comb begin
      state_nxt    = state;
      sel_nxt      = sel;
      ptr_nxt      = ptr;
      beat_cnt_nxt = beat_cnt;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt    = SERVE;
               sel_nxt      = winner;
               beat_cnt_nxt = 4'd0;
            end
         end
         SERVE: begin
            if (xfer) begin
               beat_cnt_nxt = beat_cnt + 4'd1;
               if (beat_cnt + 4'd1 == BURST_LAST) begin
                  state_nxt = IDLE;
                  ptr_nxt   = sel + 2'd1;
               end
            end else if (!req[sel]) begin
               state_nxt = IDLE;
               ptr_nxt   = sel + 2'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sel      <= 2'd0;
         ptr      <= 2'd0;
         beat_cnt <= 4'd0;
      end else begin
         state    <= state_nxt;
         sel      <= sel_nxt;
         ptr      <= ptr_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: a MAX_BURST=4 instance for burst/backpressure/release/reset
// scenarios and a MAX_BURST=2 instance for rotation order; transfers scored from queues.
module tb_rr_mux_arbiter;

   typedef struct {
      int         idx;
      logic [7:0] data;
   } exp_t;

   logic        clk;
   logic        rst_n;

   logic [3:0]  req_a, ack_a;
   logic [31:0] din_a;
   logic [1:0]  sel_a;
   logic [7:0]  out_data_a;
   logic        out_valid_a, out_ready_a, busy_a;

   logic [3:0]  req_b, ack_b;
   logic [31:0] din_b;
   logic [1:0]  sel_b;
   logic [7:0]  out_data_b;
   logic        out_valid_b, out_ready_b, busy_b;

   int   checks = 0;
   int   errors = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   exp_t e_a, e_b;

   rr_mux_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .req(req_a), .din(din_a), .ack(ack_a), .sel(sel_a),
      .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a), .busy(busy_a)
   );

   rr_mux_arbiter #(.WIDTH(8), .MAX_BURST(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req_b), .din(din_b), .ack(ack_b), .sel(sel_b),
      .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .busy(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboards: every ack must match the next expected (requester, data) pair.
   always @(negedge clk) begin
      if (ack_a !== 4'b0000) begin
         checks++;
         if (q_a.size() == 0) begin
            errors++;
            $display("FAIL sb_a_unexpected: ack=%b data=%h with no transfer expected", ack_a, out_data_a);
         end else begin
            e_a = q_a.pop_front();
            if (ack_a !== (4'b0001 << e_a.idx) || out_data_a !== e_a.data) begin
               errors++;
               $display("FAIL sb_a_xfer: ack=%b data=%h, required ack bit %0d data=%h",
                        ack_a, out_data_a, e_a.idx, e_a.data);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (ack_b !== 4'b0000) begin
         checks++;
         if (q_b.size() == 0) begin
            errors++;
            $display("FAIL sb_b_unexpected: ack=%b data=%h with no transfer expected", ack_b, out_data_b);
         end else begin
            e_b = q_b.pop_front();
            if (ack_b !== (4'b0001 << e_b.idx) || out_data_b !== e_b.data) begin
               errors++;
               $display("FAIL sb_b_xfer: ack=%b data=%h, required ack bit %0d data=%h",
                        ack_b, out_data_b, e_b.idx, e_b.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input int idx, input logic [7:0] data, input int n);
      for (int k = 0; k < n; k++) q_a.push_back('{idx, data});
   endtask

   task automatic push_b(input int idx, input logic [7:0] data, input int n);
      for (int k = 0; k < n; k++) q_b.push_back('{idx, data});
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      req_a       = 4'b1111;
      din_a       = {8'h44, 8'h33, 8'h22, 8'h11};
      out_ready_a = 1'b1;
      req_b       = 4'b0000;
      din_b       = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
      out_ready_b = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid_a); end
      checks++;
      if (ack_a !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b want 0000", ack_a); end
      checks++;
      if (sel_a !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", sel_a); end
      checks++;
      if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
      checks++;
      if (out_data_a !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", out_data_a); end
      push_a(0, 8'h11, 4);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy_a !== 1'b0 || out_valid_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_idle: busy=%b valid=%b want 0 0", busy_a, out_valid_a);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (busy_a !== 1'b1 || sel_a !== 2'd0 || out_valid_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant beat %0d: busy=%b sel=%0d valid=%b want 1 0 1",
                     i, busy_a, sel_a, out_valid_a);
         end
      end
      tick();
      req_a = 4'b0000;
      repeat (2) tick();
   endtask

   task automatic test_single_burst();
      logic exp_on;
      din_a[23:16] = 8'hA5;
      push_a(2, 8'hA5, 5);
      req_a = 4'b0100;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         exp_on = (i != 0 && i != 5);
         checks++;
         if (busy_a !== exp_on || ack_a[2] !== exp_on) begin
            errors++;
            $display("FAIL burst_pattern cycle %0d: busy=%b ack=%b want busy=%b ack2=%b",
                     i, busy_a, ack_a, exp_on, exp_on);
         end
         if (i == 5) begin
            checks++;
            if (dut_a.ptr !== 2'd3) begin errors++; $display("FAIL burst_ptr: got %0d want 3", dut_a.ptr); end
         end
         if (i == 6) begin
            checks++;
            if (sel_a !== 2'd2) begin errors++; $display("FAIL burst_regrant: sel=%0d want 2", sel_a); end
         end
      end
      tick();
      req_a = 4'b0000;
      repeat (2) tick();
   endtask

   task automatic test_backpressure();
      logic exp_ack, exp_valid;
      din_a[15:8] = 8'h22;
      push_a(1, 8'h22, 4);
      req_a       = 4'b0010;
      out_ready_a = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         exp_ack   = (i == 1 || i == 2 || i == 6 || i == 7);
         exp_valid = (i >= 1 && i <= 7);
         checks++;
         if (ack_a[1] !== exp_ack || out_valid_a !== exp_valid || busy_a !== exp_valid) begin
            errors++;
            $display("FAIL bp_pattern cycle %0d: ack=%b valid=%b busy=%b want ack1=%b valid=%b",
                     i, ack_a, out_valid_a, busy_a, exp_ack, exp_valid);
         end
         if (i >= 3 && i <= 5) begin
            checks++;
            if (out_data_a !== 8'h22 || sel_a !== 2'd1 || dut_a.beat_cnt !== 4'd2 || ack_a !== 4'b0000) begin
               errors++;
               $display("FAIL bp_stall cycle %0d: data=%h sel=%0d beat_cnt=%0d ack=%b want 22 1 2 0000",
                        i, out_data_a, sel_a, dut_a.beat_cnt, ack_a);
            end
         end
         if (i == 2) begin tick(); out_ready_a = 1'b0; end
         if (i == 5) begin tick(); out_ready_a = 1'b1; end
         if (i == 7) begin tick(); req_a = 4'b0000; end
      end
      repeat (2) tick();
   endtask

   task automatic test_early_release();
      push_a(3, 8'h44, 1);
      push_a(0, 8'h11, 1);
      req_a = 4'b1001;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         case (i)
            0: begin
               checks++;
               if (busy_a !== 1'b0) begin errors++; $display("FAIL rel_idle0: busy=%b want 0", busy_a); end
            end
            1: begin
               checks++;
               if (sel_a !== 2'd3 || ack_a !== 4'b1000) begin
                  errors++; $display("FAIL rel_grant3: sel=%0d ack=%b want 3 1000", sel_a, ack_a);
               end
               tick();
               req_a = 4'b0001;
            end
            2: begin
               checks++;
               if (busy_a !== 1'b1 || out_valid_a !== 1'b0 || ack_a !== 4'b0000) begin
                  errors++;
                  $display("FAIL rel_drop: busy=%b valid=%b ack=%b want 1 0 0000", busy_a, out_valid_a, ack_a);
               end
            end
            3: begin
               checks++;
               if (busy_a !== 1'b0 || dut_a.ptr !== 2'd0) begin
                  errors++; $display("FAIL rel_ptr: busy=%b ptr=%0d want 0 0", busy_a, dut_a.ptr);
               end
            end
            4: begin
               checks++;
               if (sel_a !== 2'd0 || ack_a !== 4'b0001) begin
                  errors++; $display("FAIL rel_grant0: sel=%0d ack=%b want 0 0001", sel_a, ack_a);
               end
               tick();
               req_a = 4'b0000;
            end
            default: begin
               checks++;
               if (out_valid_a !== 1'b0 || ack_a !== 4'b0000) begin
                  errors++; $display("FAIL rel_end: valid=%b ack=%b want 0 0000", out_valid_a, ack_a);
               end
            end
         endcase
      end
      repeat (2) tick();
   endtask

   task automatic test_round_robin();
      int exp_sel;
      for (int g = 0; g < 5; g++) push_b(g % 4, din_b[(g % 4)*8 +: 8], 2);
      req_b = 4'b1111;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         exp_sel = ((i - 1) / 3) % 4;
         checks++;
         if (i % 3 == 0) begin
            if (busy_b !== 1'b0 || ack_b !== 4'b0000) begin
               errors++;
               $display("FAIL rr_gap cycle %0d: busy=%b ack=%b want 0 0000", i, busy_b, ack_b);
            end
         end else if (busy_b !== 1'b1 || sel_b !== 2'(exp_sel) || ack_b !== (4'b0001 << exp_sel)) begin
            errors++;
            $display("FAIL rr_grant cycle %0d: busy=%b sel=%0d ack=%b want sel %0d", i, busy_b, sel_b, ack_b, exp_sel);
         end
      end
      tick();
      req_b = 4'b0000;
      repeat (2) tick();
   endtask

   task automatic test_async_reset();
      din_a[23:16] = 8'h5A;
      push_a(2, 8'h5A, 1);
      req_a = 4'b0100;
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #2;
      checks++;
      if (out_valid_a !== 1'b1 || ack_a !== 4'b0100) begin
         errors++; $display("FAIL arst_pre: valid=%b ack=%b want 1 0100", out_valid_a, ack_a);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid_a !== 1'b0 || ack_a !== 4'b0000 || busy_a !== 1'b0 || out_data_a !== 8'h00) begin
         errors++;
         $display("FAIL arst_immediate: valid=%b ack=%b busy=%b data=%h want 0 0000 0 00",
                  out_valid_a, ack_a, busy_a, out_data_a);
      end
      tick();
      checks++;
      if (sel_a !== 2'd0 || dut_a.state !== dut_a.IDLE) begin
         errors++; $display("FAIL arst_state: sel=%0d state=%0d want 0 IDLE", sel_a, dut_a.state);
      end
      req_a = 4'b0000;
      rst_n = 1'b1;
      repeat (2) tick();
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_backpressure();
      test_early_release();
      test_round_robin();
      test_async_reset();
      checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d/%0d transfers left, want 0/0", q_a.size(), q_b.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit output channel between four requesters.
- Drives the select of a 4:1 data mux internally and runs a valid/ready handshake on the shared output.
- Grants a requester a burst of up to MAX_BURST beats, then rotates priority.
- Sits between four producer blocks and a single downstream consumer.

Parameters:
- WIDTH, 8, data width of each requester and of the output channel.
- MAX_BURST, 4, maximum beats transferred per grant before forced rotation; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; bit i high = requester i has a beat ready on din.
- din  input  4*WIDTH  packed data; din[i*WIDTH +: WIDTH] belongs to requester i; held stable while req[i]=1 and ack[i]=0.
- ack  output  4  one-hot; ack[i]=1 in the cycle a beat from requester i transfers.
- sel  output  2  index of the currently granted requester.
- out_data  output  WIDTH  shared output data.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts the beat when out_valid=1 and out_ready=1.
- busy  output  1  high while in SERVE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, sel=0, ptr=0, beat_cnt=0.
  - out_valid=0, out_data=0, ack=0, busy=0.
  - Reset mid-burst aborts immediately; no ack is issued in the reset cycle.
- ptr (2 bits) is the highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3, mod 4.
- IDLE:
  - out_valid=0.
  - If req!=0, the first set bit in search order wins: next state=SERVE, sel<=winner, beat_cnt<=0.
  - If req=0, stay in IDLE; sel holds its value.
- SERVE:
  - out_valid = req[sel], combinational.
  - out_data = din[sel] when out_valid=1, else 0. This path is combinational.
  - busy=1.
  - Transfer when out_valid && out_ready: ack[sel]=1 (combinational, same cycle), beat_cnt increments.
  - If the transfer takes beat_cnt to MAX_BURST: next state=IDLE, ptr<=sel+1 (wraps 3->0).
  - If req[sel]=0 at an edge with no transfer (requester done or withdrawn): next state=IDLE, ptr<=sel+1.
  - Otherwise stay in SERVE with sel unchanged; the grant is held regardless of other requests.
- Latency:
  - Request to first out_valid: 1 cycle (IDLE->SERVE).
  - At least one IDLE cycle separates consecutive grants, so peak throughput is MAX_BURST/(MAX_BURST+1) with out_ready constantly high.
- Backpressure: with out_ready=0, out_valid and out_data stay stable, beat_cnt and sel are frozen, and ack=0.
- Simultaneous requests: only the winner in search order is served; all others wait and no ack goes to non-granted requesters.
- New req bits arriving during SERVE have no effect until the next IDLE.
- MAX_BURST=1 rotates after every beat.
- beat_cnt width is 4 bits; it never exceeds MAX_BURST.
- ack is never asserted in IDLE. At most one ack bit is high in any cycle.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> out_valid=0, ack=0, sel=0, busy=0. Release reset -> first grant to requester 0 one cycle later.
- Single long burst: req=4'b0100, din2=8'hA5, out_ready=1, MAX_BURST=4 -> exactly 4 acks on bit 2 over 4 consecutive cycles, then 1 IDLE cycle, then regrant to 2 with ptr=3.
- Round-robin fairness: req=4'b1111 constant, out_ready=1, MAX_BURST=2 -> grant order 0,1,2,3,0; each grant delivers 2 beats; idle gap of 1 cycle between grants.
- Backpressure: granted requester 1, out_ready low for 3 cycles mid-burst -> out_data and out_valid stable, ack=0, beat_cnt frozen; the burst completes when out_ready returns.
- Early release: requester 3 drops req after 1 beat with MAX_BURST=4 -> IDLE next cycle, ptr=0, and pending requester 0 is granted.
- Async reset mid-burst: assert rst_n=0 during SERVE between clock edges -> out_valid and ack go to 0 immediately without waiting for a clock edge, and state returns to IDLE.
